// File: rtl/uart_tx_fifo_mmio_if.sv
// CPU memory-bus port of the buffered UART transmitter: address, write data,
// write strobe, byte lanes, and the registered read-data return path.
interface uart_tx_fifo_mmio_if;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] memReadData;

  modport master (
    output memAddress, memWriteData, memWrite, byteMask,
    input  memReadData
  );

  modport slave (
    input  memAddress, memWriteData, memWrite, byteMask,
    output memReadData
  );
endinterface

// File: rtl/uart_tx_fifo_mmio.sv
// MMIO UART transmitter: TXDATA pushes bytes into a FIFO, STATUS reports
// full/empty/busy/overflow/count, and an FSM drains the FIFO as 8N1 frames.
//
// state   | meaning
// S_IDLE  | line high; pops the FIFO head when the FIFO is non-empty
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module uart_tx_fifo_mmio #(
  parameter logic [31:0] BASE_MEMORY  = 32'hFFFF_FFE8,
  parameter logic [31:0] TOP_MEMORY   = 32'hFFFF_FFEF,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  uart_tx_fifo_mmio_if.slave        bus,
  output logic                      uart_tx,
  output logic                      tx_empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [BW-1:0]   r_baud, w_baud_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_tx, w_tx_nxt;
  logic [AW:0]     r_wptr, r_rptr, w_count;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic            r_ovf;
  logic [31:0]     r_rdata, w_status;
  logic            w_sel, w_wr_data, w_wr_stat, w_empty, w_full, w_pop, w_push;
  logic            w_unused_bits;

  assign w_sel     = (bus.memAddress >= BASE_MEMORY) && (bus.memAddress <= TOP_MEMORY);
  assign w_wr_data = w_sel && bus.memWrite && bus.byteMask[0] && !bus.memAddress[2];
  assign w_wr_stat = w_sel && bus.memWrite && bus.byteMask[0] && bus.memAddress[2];

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_count == FULL_CNT);

  // Pop decision uses pre-push occupancy, so a push into an empty FIFO pops next cycle
  assign w_pop  = (r_state == S_IDLE) && !w_empty;
  assign w_push = w_wr_data && (!w_full || w_pop);

  assign w_unused_bits = &{1'b0, bus.memWriteData[31:8], bus.byteMask[3:1]};

  always_comb begin
    w_status          = '0;
    w_status[0]       = w_full;
    w_status[1]       = w_empty;
    w_status[2]       = (r_state != S_IDLE);
    w_status[3]       = r_ovf;
    w_status[8 +: AW+1] = w_count;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BW'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    unique case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (w_pop) begin
          w_state_nxt = S_START;
          w_shift_nxt = r_mem[r_rptr[AW-1:0]];
          w_bit_nxt   = '0;
        end
      end
      S_START: begin
        if (r_baud == BAUD_LAST) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_bit_nxt   = '0;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
          end
        end
      end
      S_STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
    // Line level is registered from the next state so uart_tx never glitches
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_ovf   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (w_push) r_wptr <= r_wptr + (AW + 1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW + 1)'(1);
      if (w_wr_data && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr_stat && bus.memWriteData[3]) r_ovf <= 1'b0;
      if (w_sel) r_rdata <= bus.memAddress[2] ? w_status : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.memWriteData[7:0];
  end

  assign bus.memReadData = r_rdata;
  assign uart_tx         = r_tx;
  assign tx_empty        = w_empty && (r_state == S_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo_mmio.sv
// Bench for uart_tx_fifo_mmio: directed steps plus random bus traffic, checked
// every cycle against a queue-and-timestamp model of the FIFO and serial line.
module tb_uart_tx_fifo_mmio;
  localparam int          N       = 4;
  localparam int          D       = 4;
  localparam int          FRAME   = 10 * N;
  localparam logic [31:0] BASE    = 32'hFFFF_FFE8;
  localparam logic [31:0] TOP     = 32'hFFFF_FFEF;
  localparam logic [31:0] TXDATA  = BASE;
  localparam logic [31:0] STATUS  = BASE + 32'd4;

  logic clk;
  logic reset;
  logic uart_tx;
  logic tx_empty;

  uart_tx_fifo_mmio_if bus_if ();

  uart_tx_fifo_mmio #(
    .BASE_MEMORY  (BASE),
    .TOP_MEMORY   (TOP),
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_if.slave),
    .uart_tx  (uart_tx),
    .tx_empty (tx_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending bytes, sticky overflow, the frame on the line (start edge + byte)
  logic [7:0]  q_pend [$];
  logic        m_ovf   = 1'b0;
  logic        f_valid = 1'b0;
  int          f_start = 0;
  logic [7:0]  f_byte  = 8'h00;
  logic [31:0] m_rdata = 32'h0;
  int          m_t     = 0;
  logic        m_valid = 1'b0;

  function automatic logic busy_at(input int t);
    return f_valid && (t >= f_start) && (t < f_start + FRAME);
  endfunction

  function automatic logic line_at(input int t);
    int k;
    if (busy_at(t)) begin
      k = (t - f_start) / N;
      if (k == 0) return 1'b0;
      if (k <= 8) return f_byte[k-1];
      return 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] status_now();
    logic [31:0] s;
    s       = '0;
    s[0]    = (q_pend.size() == D);
    s[1]    = (q_pend.size() == 0);
    s[2]    = busy_at(m_t);
    s[3]    = m_ovf;
    s[16:8] = 9'(q_pend.size());
    return s;
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic we,
                            input logic [3:0] bm, input logic rst);
    logic sel, pop;
    int   e;
    e = m_t + 1;
    if (rst) begin
      q_pend.delete();
      m_ovf   = 1'b0;
      f_valid = 1'b0;
      m_rdata = 32'h0;
      m_valid = 1'b1;
      m_t     = e;
      return;
    end
    sel = (a >= BASE) && (a <= TOP);
    if (sel) m_rdata = a[2] ? status_now() : 32'h0;
    pop = !busy_at(m_t) && (q_pend.size() > 0);
    if (sel && we && bm[0] && !a[2]) begin
      if (q_pend.size() < D || pop) q_pend.push_back(wd[7:0]);
      else m_ovf = 1'b1;
    end
    if (sel && we && bm[0] && a[2] && wd[3]) m_ovf = 1'b0;
    if (pop) begin
      f_byte  = q_pend.pop_front();
      f_start = e;
      f_valid = 1'b1;
    end
    m_t = e;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, m_t, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic [3:0] bm, input logic rst);
    if (m_valid) begin
      chk("uart_tx", {31'b0, uart_tx}, {31'b0, line_at(m_t)});
      chk("tx_empty", {31'b0, tx_empty},
          {31'b0, (q_pend.size() == 0) && !busy_at(m_t)});
      chk("rdata", bus_if.memReadData, m_rdata);
    end
    bus_if.memAddress   = a;
    bus_if.memWriteData = wd;
    bus_if.memWrite     = we;
    bus_if.byteMask     = bm;
    reset               = rst;
    model_edge(a, wd, we, bm, rst);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] bm);
    step(a, wd, 1'b1, bm, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] exp);
    step(STATUS, 32'h0, 1'b0, 4'h0, 1'b0);
    chk(tag, bus_if.memReadData, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  fr;
    logic [31:0] a, wd;
    logic [3:0]  bm;
    int          guard;

    // Reset state
    for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
    rd_chk("reset_status", 32'h0000_0002);
    chk("reset_tx", {31'b0, uart_tx}, 32'h1);
    chk("reset_tx_empty", {31'b0, tx_empty}, 32'h1);

    // Single byte 0xA5: start, LSB-first data, stop, 4 cycles each
    wr(TXDATA, 32'h0000_00A5, 4'b0001);
    idle(1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      chk("a5_bit", {31'b0, uart_tx}, {31'b0, fr[i/N]});
      idle(1);
    end
    chk("a5_end_tx", {31'b0, uart_tx}, 32'h1);
    chk("a5_end_empty", {31'b0, tx_empty}, 32'h1);

    // Lane masking: no push without byte lane 0
    wr(TXDATA, 32'h0000_0055, 4'b1110);
    idle(2);
    rd_chk("mask_status", 32'h0000_0002);
    chk("mask_tx", {31'b0, uart_tx}, 32'h1);

    // Fill and overflow: six back-to-back writes, first frame in START
    for (int i = 1; i <= 6; i++) wr(TXDATA, 32'h10 + i, 4'b0001);
    rd_chk("full_status", 32'h0000_040D);
    idle(5 * (FRAME + 1) + 10);
    rd_chk("ovf_sticky", 32'h0000_000A);
    wr(STATUS, 32'h0000_0008, 4'b0001);
    rd_chk("ovf_cleared", 32'h0000_0002);

    // Wrap-around: 3*DEPTH incrementing bytes, kept flowing without overflow
    for (int v = 0; v < 3 * D; v++) begin
      guard = 0;
      while (q_pend.size() >= D && guard < 200) begin
        idle(1);
        guard++;
      end
      chk("wrap_guard", {31'b0, guard < 200}, 32'h1);
      wr(TXDATA, 32'(v), 4'b0001);
    end
    idle((D + 1) * (FRAME + 1) + 10);
    rd_chk("wrap_status", 32'h0000_0002);

    // Random bus traffic around the window boundaries
    for (int i = 0; i < 400; i++) begin
      a  = BASE - 32'd8 + 32'($urandom_range(0, 19));
      wd = $urandom;
      bm = 4'($urandom_range(0, 15));
      step(a, wd, ($urandom_range(0, 9) < 6), bm, 1'b0);
    end
    idle((D + 1) * (FRAME + 1) + 10);
    wr(STATUS, 32'h0000_0008, 4'b0001);
    rd_chk("rand_drained", 32'h0000_0002);

    // Reset mid-frame during DATA bit 3 with two bytes queued
    wr(TXDATA, 32'h0000_00C3, 4'b0001);
    wr(TXDATA, 32'h0000_0081, 4'b0001);
    wr(TXDATA, 32'h0000_0042, 4'b0001);
    guard = 0;
    while (m_t < f_start + N + 3 * N + 1 && guard < 100) begin
      idle(1);
      guard++;
    end
    chk("pre_reset_queued", 32'(q_pend.size()), 32'd2);
    chk("pre_reset_bit3", {31'b0, uart_tx}, 32'h0);
    step(32'h0, 32'h0, 1'b0, 4'h0, 1'b1);
    chk("post_reset_tx", {31'b0, uart_tx}, 32'h1);
    rd_chk("post_reset_status", 32'h0000_0002);
    idle(3 * FRAME);
    chk("post_reset_quiet", {31'b0, uart_tx}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
